// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage
// ID/EX control-bundle pipeline register with hazard handling. It registers
// the decoded control bundle every cycle. On request it swaps the bundle for
// a NOP bundle, either for a single cycle (flush) or for a train of up to
// MAX_BUBBLES cycles (bubble). It holds everything on stall and keeps a
// saturating count of how many NOP bundles it has loaded.
//
// Priority on each rising edge, highest first:
//   rst > flush > stall > bubble countdown > bubble_req > normal load
//
// r_rem counts the NOPs still owed *after* the one just loaded. That is why
// a train of length L loads its first NOP on the request edge and then stays
// in BUBBLE for L-1 more edges. busy is therefore low again on the edge that
// loads the last NOP, and upstream can present its held instruction in that
// same cycle.

module ctrl_bubble_stage #(
  parameter int                CTRL_W      = 29,
  parameter logic [CTRL_W-1:0] NOP_VALUE   = {CTRL_W{1'b0}},
  parameter int                MAX_BUBBLES = 3,
  parameter int                CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble_req,
  input  logic [CNT_W-1:0]  bubble_len,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              busy,
  output logic [15:0]       bubble_total
);

  typedef enum logic {
    PASS   = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      TOTAL_MAX = 16'hFFFF;

  // Registered state
  state_t            r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic [15:0]       r_total;

  // Next-state values from the combinational process
  state_t            w_stateNext;
  logic [CNT_W-1:0]  w_remNext;
  logic [CTRL_W-1:0] w_ctrlNext;
  logic              w_validNext;
  logic [15:0]       w_totalNext;

  // Helper values shared by several branches
  logic [CNT_W-1:0]  w_len;
  logic [15:0]       w_totalInc;
  logic              w_startTrain;

  // Oversized requests are clipped to the longest train the stage supports.
  assign w_len = (bubble_len > MAX_LEN) ? MAX_LEN : bubble_len;

  // The NOP counter sticks at all-ones instead of wrapping to zero.
  assign w_totalInc = (r_total == TOTAL_MAX) ? r_total : r_total + 16'd1;

  // A zero-length request is treated as no request at all.
  assign w_startTrain = bubble_req && (w_len != CNT_ZERO);

  // State register: synchronous reset loads the NOP bundle and clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PASS;
      r_rem   <= CNT_ZERO;
      r_ctrl  <= NOP_VALUE;
      r_valid <= 1'b0;
      r_total <= 16'd0;
    end else begin
      r_state <= w_stateNext;
      r_rem   <= w_remNext;
      r_ctrl  <= w_ctrlNext;
      r_valid <= w_validNext;
      r_total <= w_totalNext;
    end
  end

  // Next-state logic: flush beats stall, stall freezes everything, then the
  // countdown of a running train, then a new train request, then a normal load
  always_comb begin
    w_stateNext = r_state;
    w_remNext   = r_rem;
    w_ctrlNext  = r_ctrl;
    w_validNext = r_valid;
    w_totalNext = r_total;

    if (flush) begin
      w_stateNext = PASS;
      w_remNext   = CNT_ZERO;
      w_ctrlNext  = NOP_VALUE;
      w_validNext = 1'b0;
      w_totalNext = w_totalInc;
    end else if (stall) begin
      w_stateNext = r_state;
    end else if (r_state == BUBBLE) begin
      w_ctrlNext  = NOP_VALUE;
      w_validNext = 1'b0;
      w_totalNext = w_totalInc;
      w_remNext   = r_rem - CNT_ONE;
      if (r_rem == CNT_ONE) begin
        w_stateNext = PASS;
      end
    end else if (w_startTrain) begin
      w_ctrlNext  = NOP_VALUE;
      w_validNext = 1'b0;
      w_totalNext = w_totalInc;
      w_remNext   = w_len - CNT_ONE;
      w_stateNext = (w_len > CNT_ONE) ? BUBBLE : PASS;
    end else begin
      w_ctrlNext  = ctrl_in;
      w_validNext = valid_in;
    end
  end

  assign ctrl_out     = r_ctrl;
  assign valid_out    = r_valid;
  assign busy         = (r_state == BUBBLE);
  assign bubble_total = r_total;

endmodule
